// File: rtl/pc_branch_unit.sv
// Program counter, architectural flag register (N, V, Z) and halt state for the 16-bit single-cycle core.
// Resolves conditional branches on registered flags and selects the next fetch address.
module pc_branch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned IMM_W    = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       flag_in,
   input  logic             flag_wr,
   input  logic             stall,
   input  logic             is_branch,
   input  logic             is_branch_reg,
   input  logic             is_halt,
   input  logic [2:0]       cond,
   input  logic [IMM_W-1:0] imm,
   input  logic [15:0]      reg_target,
   output logic [15:0]      pc,
   output logic [15:0]      pc_plus2,
   output logic [2:0]       flag,
   output logic             taken,
   output logic             halted
);

   localparam int unsigned PC_W = 16;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] br_offset;
   logic [PC_W-1:0] br_target;
   logic [2:0]      flag_d;
   logic            flag_n;
   logic            flag_v;
   logic            flag_z;
   logic            cond_true;
   logic            run_en;

   assign flag_n = flag[0];
   assign flag_v = flag[1];
   assign flag_z = flag[2];

   // Branch conditions only ever see flags written by earlier instructions.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         3'b000:  cond_true = ~flag_z;
         3'b001:  cond_true = flag_z;
         3'b010:  cond_true = ~flag_z & ~flag_n;
         3'b011:  cond_true = flag_n;
         3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
         3'b101:  cond_true = flag_n | flag_z;
         3'b110:  cond_true = flag_v;
         default: cond_true = 1'b1;
      endcase
   end

   assign taken     = (is_branch | is_branch_reg) & cond_true & (state_q == ST_RUN);
   assign pc_plus2  = pc + PC_W'(2);
   assign br_offset = PC_W'($signed(imm)) << 1;
   assign br_target = pc_plus2 + br_offset;
   assign run_en    = (state_q == ST_RUN) & ~stall;

   // Next-state: halt outranks both branch kinds, PC-relative outranks register branch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      flag_d  = flag;
      if (run_en) begin
         if (flag_wr) begin
            flag_d = flag_in;
         end
         if (is_halt) begin
            state_d = ST_HALTED;
         end else if (taken && is_branch) begin
            pc_d = br_target;
         end else if (taken && is_branch_reg) begin
            pc_d = reg_target;
         end else begin
            pc_d = pc_plus2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc      <= RESET_PC;
         flag    <= 3'b000;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         flag    <= flag_d;
         halted  <= (state_d == ST_HALTED);
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_pc_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  flag_in;
   logic        flag_wr;
   logic        stall;
   logic        is_branch;
   logic        is_branch_reg;
   logic        is_halt;
   logic [2:0]  cond;
   logic [8:0]  imm;
   logic [15:0] reg_target;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic [2:0]  flag;
   logic        taken;
   logic        halted;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   logic [15:0] m_pc;
   logic [2:0]  m_flag;
   logic        m_halted;

   pc_branch_unit #(.RESET_PC(16'h0000), .IMM_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_wr(flag_wr), .stall(stall),
      .is_branch(is_branch), .is_branch_reg(is_branch_reg), .is_halt(is_halt),
      .cond(cond), .imm(imm), .reg_target(reg_target),
      .pc(pc), .pc_plus2(pc_plus2), .flag(flag), .taken(taken), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic bit cond_holds(input logic [2:0] f, input logic [2:0] c);
      bit n, v, z;
      n = f[0]; v = f[1]; z = f[2];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit model_taken();
      return (is_branch || is_branch_reg) && cond_holds(m_flag, cond) && !m_halted;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: integer arithmetic on the architectural rules.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc     <= 16'h0000;
         m_flag   <= 3'b000;
         m_halted <= 1'b0;
      end else if (!m_halted && !stall) begin
         int nxt;
         nxt = int'(m_pc) + 2;
         if (is_halt) nxt = int'(m_pc);
         else if (model_taken() && is_branch) nxt = int'(m_pc) + 2 + 2 * int'($signed(imm));
         else if (model_taken() && is_branch_reg) nxt = int'(reg_target);
         m_pc <= 16'(nxt);
         if (flag_wr) m_flag <= flag_in;
         if (is_halt) m_halted <= 1'b1;
      end
   end

   // Compare process: every falling edge, away from input changes and the active edge.
   always @(negedge clk) begin
      chk("pc", pc, m_pc);
      chk("pc_plus2", pc_plus2, 16'(int'(m_pc) + 2));
      chk("flag", 16'(flag), 16'(m_flag));
      chk("halted", 16'(halted), 16'(m_halted));
      chk("taken", 16'(taken), 16'(model_taken()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flag_in = 3'b000; flag_wr = 1'b0; stall = 1'b0; is_branch = 1'b0;
      is_branch_reg = 1'b0; is_halt = 1'b0; cond = 3'b000; imm = 9'h000; reg_target = 16'h0000;
   endtask

   logic [7:0] exp_mask [4];
   logic [2:0] sweep_flag [4];

   initial begin
      logic [7:0] m;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_flag", 16'(flag), 16'h0000);
      chk("rst_halted", 16'(halted), 16'h0000);
      tick(); chk("seq_pc1", pc, 16'h0002);
      tick(); chk("seq_pc2", pc, 16'h0004);
      tick(); chk("seq_pc3", pc, 16'h0006);

      // async reset mid-cycle
      #2 rst_n = 1'b0;
      #1 chk("async_rst_pc", pc, 16'h0000);
      #1 rst_n = 1'b1;

      repeat (8) tick();
      chk("pc_0010", pc, 16'h0010);

      // flag write then branch on it
      flag_in = 3'b100; flag_wr = 1'b1;
      tick(); chk("fw_flag", 16'(flag), 16'h0004); chk("fw_pc", pc, 16'h0012);
      flag_wr = 1'b0; is_branch = 1'b1; cond = 3'b001; imm = 9'h1FE;
      #1 chk("b_taken", 16'(taken), 16'h0001);
      tick(); chk("b_pc", pc, 16'h0010);

      // same-cycle flag write / branch hazard
      idle_inputs(); flag_wr = 1'b1; flag_in = 3'b000;
      tick(); chk("clr_flag", 16'(flag), 16'h0000);
      flag_in = 3'b100; is_branch = 1'b1; cond = 3'b001; imm = 9'h1FE;
      #1 chk("haz_taken", 16'(taken), 16'h0000);
      tick(); chk("haz_pc", pc, 16'h0014); chk("haz_flag", 16'(flag), 16'h0004);

      // condition sweep (stall holds pc; taken ignores stall)
      sweep_flag[0] = 3'b000; exp_mask[0] = 8'h95;
      sweep_flag[1] = 3'b001; exp_mask[1] = 8'hA9;
      sweep_flag[2] = 3'b010; exp_mask[2] = 8'hD5;
      sweep_flag[3] = 3'b100; exp_mask[3] = 8'hB2;
      for (int fi = 0; fi < 4; fi++) begin
         idle_inputs(); flag_wr = 1'b1; flag_in = sweep_flag[fi];
         tick();
         idle_inputs(); stall = 1'b1; is_branch = 1'b1;
         m = exp_mask[fi];
         for (int c = 0; c < 8; c++) begin
            cond = 3'(c);
            #1 chk($sformatf("sweep_f%0d_c%0d", fi, c), 16'(taken), 16'(m[c]));
         end
         tick();
      end

      // register branch, wrap
      idle_inputs(); is_branch_reg = 1'b1; cond = 3'b111; reg_target = 16'hFFFE;
      tick(); chk("br_fffe", pc, 16'hFFFE); chk("p2_wrap", pc_plus2, 16'h0000);
      idle_inputs();
      tick(); chk("wrap_pc", pc, 16'h0000);
      is_branch_reg = 1'b1; cond = 3'b111; reg_target = 16'h1235;
      tick(); chk("br_1235", pc, 16'h1235);

      // stall holds pc and flags
      idle_inputs(); stall = 1'b1; flag_wr = 1'b1; flag_in = 3'b010;
      tick(); tick();
      chk("stall_pc", pc, 16'h1235); chk("stall_flag", 16'(flag), 16'h0004);

      // halt
      idle_inputs(); is_branch_reg = 1'b1; cond = 3'b111; reg_target = 16'h0040;
      tick();
      idle_inputs(); is_halt = 1'b1;
      tick(); chk("halt_flag", 16'(halted), 16'h0001); chk("halt_pc", pc, 16'h0040);
      idle_inputs(); is_branch = 1'b1; cond = 3'b111; imm = 9'h020; flag_wr = 1'b1; flag_in = 3'b111;
      for (int i = 0; i < 10; i++) begin
         #1 chk("halt_taken", 16'(taken), 16'h0000);
         tick(); chk("halt_hold_pc", pc, 16'h0040);
      end
      chk("halt_flag_hold", 16'(flag), 16'h0004);
      #2 rst_n = 1'b0;
      #1 chk("halt_rst_pc", pc, 16'h0000); chk("halt_rst_h", 16'(halted), 16'h0000);
      #1 rst_n = 1'b1;
      idle_inputs();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         flag_in       = 3'($urandom);
         flag_wr       = 1'($urandom);
         stall         = ($urandom_range(0, 3) == 0);
         is_branch     = 1'($urandom);
         is_branch_reg = 1'($urandom);
         is_halt       = ($urandom_range(0, 63) == 0);
         cond          = 3'($urandom);
         imm           = 9'($urandom);
         reg_target    = 16'($urandom);
         tick();
         if (m_halted && $urandom_range(0, 7) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      idle_inputs();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
